// File: rtl/dnn_loader.sv
// Frame sequencer for the dnn datapath: streams 4 inputs and 24 weights into a held
// frame, fires dnn once, captures the result pair and offers it on a valid/ready port.
module dnn_loader #(
  parameter int DATA_W  = 5,
  parameter int OUT_W   = 17,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     cfg_reuse_w,
  output logic [28*DATA_W-1:0]     frame_o,
  output logic                     in_ready,
  input  logic                     out10_ready,
  input  logic                     out11_ready,
  input  logic signed [OUT_W-1:0]  out0,
  input  logic signed [OUT_W-1:0]  out1,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [OUT_W-1:0]  res0,
  output logic signed [OUT_W-1:0]  res1,
  output logic                     err
);
  localparam int N_WORDS = 28;
  localparam int N_X     = 4;
  localparam int IDX_W   = $clog2(N_WORDS);
  localparam int CNT_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {LOAD, FIRE, WAIT, RESULT} state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [N_WORDS*DATA_W-1:0] frame_q, frame_d;
  logic                      reuse_q, reuse_d;
  logic                      w_valid_q, w_valid_d;
  logic                      in_ready_q, in_ready_d;
  logic                      res_valid_q, res_valid_d;
  logic                      err_q, err_d;
  logic signed [OUT_W-1:0]   res0_q, res0_d, res1_q, res1_d;
  logic                      reuse_cur, last_word;

  // Frame mode is decided on word 0 and held for the remaining words of the frame.
  assign reuse_cur = (idx_q == '0) ? (cfg_reuse_w && w_valid_q) : reuse_q;
  assign last_word = reuse_cur ? (idx_q == IDX_W'(N_X - 1)) : (idx_q == IDX_W'(N_WORDS - 1));

  always_comb begin
    // NOTE: every _d starts from its held value so no branch of the case can infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    frame_d     = frame_q;
    reuse_d     = reuse_q;
    w_valid_d   = w_valid_q;
    in_ready_d  = 1'b0;
    res_valid_d = res_valid_q;
    err_d       = err_q;
    res0_d      = res0_q;
    res1_d      = res1_q;
    case (state_q)
      LOAD: begin
        if (s_valid) begin
          frame_d[DATA_W*int'(idx_q) +: DATA_W] = s_data;
          reuse_d = reuse_cur;
          if (last_word) begin
            idx_d      = '0;
            state_d    = FIRE;
            in_ready_d = 1'b1;
            if (!reuse_cur) w_valid_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FIRE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // A lone ready flag is not a result; only both together trigger capture.
        if (out10_ready && out11_ready) begin
          res0_d      = out0;
          res1_d      = out1;
          res_valid_d = 1'b1;
          state_d     = RESULT;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d     = 1'b1;
          w_valid_d = 1'b0;
          state_d   = LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples its peers' pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the frame is a register bank driving dnn directly, so it is reset like any flop.
      state_q     <= LOAD;
      idx_q       <= '0;
      cnt_q       <= '0;
      frame_q     <= '0;
      reuse_q     <= 1'b0;
      w_valid_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      res0_q      <= '0;
      res1_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      reuse_q     <= reuse_d;
      w_valid_q   <= w_valid_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
      res0_q      <= res0_d;
      res1_q      <= res1_d;
    end
  end

  assign s_ready   = (state_q == LOAD);
  assign frame_o   = frame_q;
  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res0      = res0_q;
  assign res1      = res1_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dnn_loader.sv
// Self-checking bench for dnn_loader: behavioural dnn (4 -> 4 ReLU -> 2) attached,
// table vectors, hand-written corner sequences and randomized frames.
module tb_dnn_loader;
  localparam int DW = 5;
  localparam int OW = 17;
  localparam int TO = 15;
  localparam int NW = 28;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic signed [DW-1:0] s_data = '0;
  logic                 cfg_reuse_w = 1'b0;
  logic [NW*DW-1:0]     frame_o;
  logic                 in_ready;
  logic                 out10_ready, out11_ready;
  logic signed [OW-1:0] out0, out1;
  logic                 res_valid;
  logic                 res_ready = 1'b0;
  logic signed [OW-1:0] res0, res1;
  logic                 err;

  dnn_loader #(.DATA_W(DW), .OUT_W(OW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cfg_reuse_w(cfg_reuse_w), .frame_o(frame_o), .in_ready(in_ready),
    .out10_ready(out10_ready), .out11_ready(out11_ready), .out0(out0), .out1(out1),
    .res_valid(res_valid), .res_ready(res_ready), .res0(res0), .res1(res1), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int acc_cnt = 0;
  int fire_cnt = 0;

  // dnn stand-in; drop11 models a datapath that never raises out11_ready.
  bit drop11 = 1'b0;
  bit stray = 1'b0;
  logic f10 = 1'b0, f11 = 1'b0;
  logic signed [OW-1:0] d0 = '0, d1 = '0;
  int dnn_a, dnn_b;
  assign out10_ready = f10 | stray;
  assign out11_ready = f11 | stray;
  assign out0 = d0;
  assign out1 = d1;

  function automatic int word_of(input logic [NW*DW-1:0] f, input int k);
    logic signed [DW-1:0] w;
    w = f[DW*k +: DW];
    return int'(w);
  endfunction

  function automatic void nn_eval(input logic [NW*DW-1:0] f, output int r0, output int r1);
    int h;
    r0 = 0;
    r1 = 0;
    for (int j = 0; j < 4; j++) begin
      h = 0;
      for (int i = 0; i < 4; i++) h += word_of(f, i) * word_of(f, 4 + 4*i + j);
      if (h < 0) h = 0;
      r0 += h * word_of(f, 20 + 2*j);
      r1 += h * word_of(f, 21 + 2*j);
    end
  endfunction

  always @(posedge clk) begin
    if (!rst && s_valid && s_ready) acc_cnt <= acc_cnt + 1;
    if (in_ready) fire_cnt <= fire_cnt + 1;
    if (rst) begin
      f10 <= 1'b0;
      f11 <= 1'b0;
    end else if (in_ready) begin
      nn_eval(frame_o, dnn_a, dnn_b);
      d0  <= OW'(dnn_a);
      d1  <= OW'(dnn_b);
      f10 <= 1'b1;
      f11 <= !drop11;
    end else begin
      f10 <= 1'b0;
      f11 <= 1'b0;
    end
  end

  // Bench-side view of the network and of the loader's weight-valid rule.
  int cx[4];
  int cwh[4][4];
  int cwo[4][2];
  bit wv = 1'b0;
  logic [NW*DW-1:0] exp_frame;
  int m0, m1;
  logic signed [DW-1:0] word_q[$];

  function automatic logic [NW*DW-1:0] pack_frame();
    logic [NW*DW-1:0] f;
    f = '0;
    for (int i = 0; i < 4; i++) f[DW*i +: DW] = DW'(cx[i]);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) f[DW*(4 + 4*i + j) +: DW] = DW'(cwh[i][j]);
    for (int j = 0; j < 4; j++)
      for (int o = 0; o < 2; o++) f[DW*(20 + 2*j + o) +: DW] = DW'(cwo[j][o]);
    return f;
  endfunction

  task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_frame(input string nm, input logic [NW*DW-1:0] act, input logic [NW*DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic rand_x();
    for (int i = 0; i < 4; i++) cx[i] = int'($urandom_range(15)) - 8;
  endtask

  task automatic rand_w();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) cwh[i][j] = int'($urandom_range(15)) - 8;
    for (int j = 0; j < 4; j++)
      for (int o = 0; o < 2; o++) cwo[j][o] = int'($urandom_range(15)) - 8;
  endtask

  task automatic set_uniform(input int wh, input int wo);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) cwh[i][j] = wh;
    for (int j = 0; j < 4; j++)
      for (int o = 0; o < 2; o++) cwo[j][o] = wo;
  endtask

  task automatic send_words(input int n, input bit stall);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      if (stall) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      while (!s_ready && t < 100) begin
        s_valid = 1'b0;
        @(negedge clk);
        t++;
      end
      if (t >= 100) check("s_ready_wait_expired", s_ready, 1);
      s_valid = 1'b1;
      s_data  = word_q[i];
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  // Leaves the bench at the negedge of the cycle right after the last accepted word.
  task automatic send_frame(input bit cfg, input bit stall, output int n);
    exp_frame = pack_frame();
    nn_eval(exp_frame, m0, m1);
    n = (cfg && wv) ? 4 : NW;
    word_q.delete();
    for (int k = 0; k < n; k++) word_q.push_back(exp_frame[DW*k +: DW]);
    cfg_reuse_w = cfg;
    send_words(n, stall);
    cfg_reuse_w = 1'b0;
    if (n == NW) wv = 1'b1;
  endtask

  task automatic run_frame(input string nm, input bit cfg, input bit stall, input int hold,
                           input bit use_e, input int e0, input int e1);
    int n, acc0, fire0;
    acc0  = acc_cnt;
    fire0 = fire_cnt;
    send_frame(cfg, stall, n);
    check({nm, " in_ready_fire"}, in_ready, 1);
    check({nm, " s_ready_fire"}, s_ready, 0);
    @(negedge clk);
    check({nm, " in_ready_single"}, in_ready, 0);
    check({nm, " res_valid_early"}, res_valid, 0);
    @(negedge clk);
    check({nm, " res_valid_n3"}, res_valid, 1);
    check({nm, " res0_model"}, res0, m0);
    check({nm, " res1_model"}, res1, m1);
    if (use_e) begin
      check({nm, " res0_table"}, res0, e0);
      check({nm, " res1_table"}, res1, e1);
    end
    check_frame({nm, " frame"}, frame_o, exp_frame);
    check({nm, " words_accepted"}, acc_cnt - acc0, n);
    check({nm, " fire_count"}, fire_cnt - fire0, 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({nm, " hold_valid"}, res_valid, 1);
      check({nm, " hold_res0"}, res0, m0);
      check({nm, " hold_res1"}, res1, m1);
      check({nm, " hold_s_ready"}, s_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({nm, " res_valid_drop"}, res_valid, 0);
    check({nm, " back_to_load"}, s_ready, 1);
  endtask

  typedef struct {
    int x0, x1, x2, x3;
    int wh, wo;
    bit reuse;
    int e0, e1;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int n;
    vecs[0] = '{1, 2, 3, 4, 1, 1, 1'b0, 40, 40};
    vecs[1] = '{2, 2, 2, 2, 0, 0, 1'b1, 32, 32};
    vecs[2] = '{1, 1, 1, 1, -1, 1, 1'b0, 0, 0};
    vecs[3] = '{1, 1, 1, 1, 2, -1, 1'b0, -32, -32};
    vecs[4] = '{3, 0, -1, 2, 0, 0, 1'b1, -32, -32};
    vecs[5] = '{-16, -16, -16, -16, -16, 15, 1'b0, 61440, 61440};
    vecs[6] = '{15, 15, 15, 15, 0, 0, 1'b1, 0, 0};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_frame("reset frame_o", frame_o, '0);
    check("reset s_ready", s_ready, 1);
    check("reset in_ready", in_ready, 0);
    check("reset res_valid", res_valid, 0);
    check("reset res0", res0, 0);
    check("reset res1", res1, 0);
    check("reset err", err, 0);

    for (int v = 0; v < 7; v++) begin
      if (!vecs[v].reuse) set_uniform(vecs[v].wh, vecs[v].wo);
      cx[0] = vecs[v].x0;
      cx[1] = vecs[v].x1;
      cx[2] = vecs[v].x2;
      cx[3] = vecs[v].x3;
      run_frame($sformatf("vec%0d", v), vecs[v].reuse, 1'b0, 0, 1'b1, vecs[v].e0, vecs[v].e1);
    end

    // Ready flags while loading must not produce a result.
    stray = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stray res_valid", res_valid, 0);
      check("stray s_ready", s_ready, 1);
    end
    stray = 1'b0;

    rand_w();
    rand_x();
    run_frame("stall", 1'b0, 1'b1, 5, 1'b0, 0, 0);

    // out11_ready never rises: err exactly TO+1 cycles after FIRE.
    drop11 = 1'b1;
    rand_w();
    rand_x();
    send_frame(1'b0, 1'b0, n);
    check("to fire", in_ready, 1);
    repeat (TO) @(negedge clk);
    check("to err_before", err, 0);
    check("to no_capture", res_valid, 0);
    @(negedge clk);
    check("to err_set", err, 1);
    check("to back_to_load", s_ready, 1);
    check("to res_valid", res_valid, 0);
    drop11 = 1'b0;
    wv = 1'b0;
    rand_w();
    rand_x();
    run_frame("after_to", 1'b1, 1'b0, 0, 1'b0, 0, 0);
    check("to err_sticky", err, 1);

    // Reset after 10 words of a frame.
    rand_w();
    rand_x();
    exp_frame = pack_frame();
    word_q.delete();
    for (int k = 0; k < NW; k++) word_q.push_back(exp_frame[DW*k +: DW]);
    send_words(10, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wv = 1'b0;
    check_frame("midrst frame_o", frame_o, '0);
    check("midrst s_ready", s_ready, 1);
    check("midrst err", err, 0);
    check("midrst res_valid", res_valid, 0);
    check("midrst res0", res0, 0);
    check("midrst in_ready", in_ready, 0);
    rand_w();
    rand_x();
    run_frame("post_rst", 1'b1, 1'b0, 0, 1'b0, 0, 0);

    for (int r = 0; r < 20; r++) begin
      bit cfg;
      cfg = 1'($urandom_range(1));
      if (!(cfg && wv)) rand_w();
      rand_x();
      run_frame($sformatf("rnd%0d", r), cfg, 1'($urandom_range(1)), int'($urandom_range(3)),
                1'b0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
